booth_product_acc: RTL and testbench
====================================

// Module: booth_product_acc
// PURPOSE
//  Downstream consumer of the 4x4 Booth multiplier: sign-extends and accumulates a
//  run of LEN signed products into a wide dot-product sum, then holds the sum under a
//  valid/ready handshake until the next stage takes it. One run is one dot product.
//  Tracks signed overflow per run; saturation is optional at build time.
// PARAMETERS
//  PW  8   product width (signed); matches the multiplier result width
//  AW  12  accumulator/sum width (signed), AW >= PW
//  CW  4   run-length counter width; LEN range 0..2**CW-1
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  start_i      in   1   begin a run; sampled only in IDLE
//  len_i        in   CW  number of products in the run, latched on start_i
//  clr_i        in   1   synchronous abort; returns to IDLE from any state
//  prod_i       in   PW  signed product from multiplier
//  prod_valid_i in   1   prod_i valid
//  prod_ready_o out  1   block accepts prod_i this cycle
//  sum_o        out  AW  signed accumulated sum
//  sum_valid_o  out  1   sum_o valid, held until taken
//  sum_ready_i  in   1   downstream takes sum_o
//  ovf_o        out  1   sticky signed overflow seen in current/last run
//  busy_o       out  1   state != IDLE
// BEHAVIOUR
//  Reset: synchronous on rst=1; state IDLE; acc, cnt, len 0; prod_ready_o, sum_valid_o,
//   ovf_o, busy_o 0; sum_o 0. Priority: rst > clr_i > all other inputs.
//  All outputs registered or decoded from registered state; no comb path input->output.
//  Product accept = prod_valid_i & prod_ready_o. Output take = sum_valid_o & sum_ready_i.
//  FSM:
//   IDLE : prod_ready_o=0, sum_valid_o=0. start_i=1 -> latch len, acc<=0, cnt<=0,
//          ovf<=0; len_i!=0 -> ACCUM, len_i==0 -> HOLD (sum 0).
//   ACCUM: prod_ready_o=1. Each accept: acc<=acc+sext(prod_i), cnt<=cnt+1. Accept while
//          cnt==len-1 -> HOLD. No accept -> state and acc unchanged (gaps legal).
//   HOLD : prod_ready_o=0, sum_valid_o=1, sum_o=acc stable. Take -> IDLE; sum_valid_o
//          low the following cycle. start_i ignored outside IDLE (not queued).
//  Latency: sum_valid_o rises the cycle after the last product accept.
//  Back-to-back: earliest next start_i accept is the cycle after the take.
//  Arithmetic: AW+1-bit signed add of acc and PW->AW sign-extended product; overflow when
//   the two operands share sign and the AW-bit result sign differs. ovf_o sets on any
//   overflowing accept, stays set until next start_i accept or clr_i/rst.
//  clr_i=1: next cycle IDLE, acc/cnt 0, ovf_o 0, all handshake outputs 0; any in-flight
//   product or unsent sum is dropped.
//  cnt wraps never: max len 2**CW-1 reached via cnt==len-1 compare.
// CONFIGURATION
//  BOOTH_ACC_SATURATE_EN defined: on overflow acc clamps to +(2**(AW-1)-1) or
//   -(2**(AW-1)) per operand sign; further accepts continue from the clamped value.
//  Not defined: acc wraps modulo 2**AW. ovf_o behaves identically in both builds.
// TESTING
//  1 rst=1 two cycles mid-run -> all outputs 0, busy_o 0, start_i accepted next cycle.
//  2 len=3, prods 5,-7,20 no gaps -> sum_valid_o 1 cycle after 3rd accept, sum_o=18,
//    ovf_o=0; sum_ready_i=1 -> busy_o 0 next cycle.
//  3 len=4, prod_valid_i with 2-cycle gaps, sum_ready_i low 5 cycles -> prod_ready_o 0
//    and sum_o=const in HOLD; only 4 products consumed; extra start_i in HOLD ignored.
//  4 AW=10, len=5, prod 127 x5 -> SATURATE_EN: sum_o=511, ovf_o=1;
//    without: sum_o=-389 (635-1024), ovf_o=1. Repeat with -128 x5 -> -512 / 384.
//  5 len=4, clr_i after 2 accepts -> IDLE next cycle, ovf_o 0; then len=1, prod -128
//    -> sum_o=-128, sum_valid_o 1.
//  6 len=0 start_i -> sum_valid_o next cycle, sum_o=0, prod_ready_o never asserted.

Source files
------------

// File: rtl/booth_product_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_product_acc_if
// Brief    : Product-in / sum-out handshake bundle for booth_product_acc.
// Revision : 1.0
// ============================================================================
interface booth_product_acc_if #(
  parameter int PW = 8,
  parameter int AW = 12,
  parameter int CW = 4
);
  logic          start_i;
  logic [CW-1:0] len_i;
  logic          clr_i;
  logic [PW-1:0] prod_i;
  logic          prod_valid_i;
  logic          prod_ready_o;
  logic [AW-1:0] sum_o;
  logic          sum_valid_o;
  logic          sum_ready_i;
  logic          ovf_o;
  logic          busy_o;

  modport slave (
    input  start_i, len_i, clr_i, prod_i, prod_valid_i, sum_ready_i,
    output prod_ready_o, sum_o, sum_valid_o, ovf_o, busy_o
  );

  modport master (
    output start_i, len_i, clr_i, prod_i, prod_valid_i, sum_ready_i,
    input  prod_ready_o, sum_o, sum_valid_o, ovf_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/booth_product_acc.sv
`default_nettype none
// ============================================================================
// Module   : booth_product_acc
// Brief    : Accumulates a run of signed products into a dot-product sum held
//            under valid/ready. Define BOOTH_ACC_SATURATE_EN to clamp on overflow.
// Revision : 1.0
// ============================================================================
module booth_product_acc #(
  parameter int PW = 8,
  parameter int AW = 12,
  parameter int CW = 4
) (
  input  logic                clk,
  input  logic                rst,
  booth_product_acc_if.slave  bus
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_ACCUM = 2'd1;
  localparam logic [1:0]    S_HOLD  = 2'd2;
  localparam logic [CW-1:0] c_one   = CW'(1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_len;
  logic                 r_ovf;

  logic                 w_prod_ready;
  logic                 w_sum_valid;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_take;
  logic                 w_last;

  logic signed [PW-1:0] w_prod_s;
  logic signed [AW-1:0] w_ext;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_acc_nxt;
  logic                 w_ovf;

  // Signed overflow: operands agree in sign but the AW-bit result does not.
  assign w_prod_s = $signed(bus.prod_i);
  assign w_ext    = w_prod_s;
  assign w_sum    = r_acc + w_ext;
  assign w_ovf    = (r_acc[AW-1] == w_ext[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]);

`ifdef BOOTH_ACC_SATURATE_EN
  localparam logic signed [AW-1:0] c_acc_max = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] c_acc_min = {1'b1, {(AW-1){1'b0}}};
  assign w_acc_nxt = w_ovf ? (r_acc[AW-1] ? c_acc_min : c_acc_max) : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  assign w_accept = bus.prod_valid_i & w_prod_ready;
  assign w_take   = w_sum_valid & bus.sum_ready_i;
  assign w_last   = (r_cnt == (r_len - c_one));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clr_i overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            w_state_nxt = (bus.len_i != '0) ? S_ACCUM : S_HOLD;
          end
        end
        S_ACCUM: begin
          if (w_accept && w_last) begin
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_take) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    w_prod_ready = 1'b0;
    w_sum_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_ACCUM: begin
        w_prod_ready = 1'b1;
        w_busy       = 1'b1;
      end
      S_HOLD: begin
        w_sum_valid  = 1'b1;
        w_busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Run datapath
  always_ff @(posedge clk) begin
    if (rst || bus.clr_i) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.start_i) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= bus.len_i;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + c_one;
      r_ovf <= r_ovf | w_ovf;
    end
  end

  assign bus.prod_ready_o = w_prod_ready;
  assign bus.sum_valid_o  = w_sum_valid;
  assign bus.busy_o       = w_busy;
  assign bus.sum_o        = r_acc;
  assign bus.ovf_o        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_booth_product_acc.sv
`default_nettype none
// Randomized and directed bench for booth_product_acc; integer reference model
// of the dot-product run, compared on every cycle at the falling edge.
module tb_booth_product_acc;
  localparam int PW   = 8;
  localparam int AW   = 10;
  localparam int CW   = 4;
  localparam int SMAX = 2**(AW-1) - 1;
  localparam int SMIN = -(2**(AW-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_product_acc_if #(.PW(PW), .AW(AW), .CW(CW)) bus ();
  booth_product_acc #(.PW(PW), .AW(AW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  logic chk_en  = 1'b0;
  logic exp_ready = 1'b0, exp_valid = 1'b0, exp_busy = 1'b0, exp_ovf = 1'b0;
  logic chk_sum = 1'b0;
  int   exp_sum = 0;
  int   m_acc   = 0;
  logic m_ovf   = 1'b0;
  int   pq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("prod_ready_o", int'(bus.prod_ready_o), int'(exp_ready));
      chk("sum_valid_o",  int'(bus.sum_valid_o),  int'(exp_valid));
      chk("busy_o",       int'(bus.busy_o),       int'(exp_busy));
      chk("ovf_o",        int'(bus.ovf_o),        int'(exp_ovf));
      if (chk_sum) chk("sum_o", int'($signed(bus.sum_o)), exp_sum);
    end
  end

  // Reference: exact integer sum, range-checked, then wrapped or clamped
  function automatic void m_step(input int p);
    int t;
    t = m_acc + p;
    if (t > SMAX || t < SMIN) begin
      m_ovf = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
      t = (t > SMAX) ? SMAX : SMIN;
`else
      t = (t > SMAX) ? t - 2**AW : t + 2**AW;
`endif
    end
    m_acc = t;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_expect();
    exp_busy = 1'b0; exp_valid = 1'b0; exp_ready = 1'b0;
  endtask

  task automatic begin_run(input int len);
    bus.start_i = 1'b1;
    bus.len_i   = CW'(len);
    cycle();
    bus.start_i = 1'b0;
    bus.len_i   = CW'($urandom);
    m_acc = 0; m_ovf = 1'b0;
    exp_busy = 1'b1; exp_ovf = 1'b0;
    if (len == 0) begin
      exp_ready = 1'b0; exp_valid = 1'b1; exp_sum = 0; chk_sum = 1'b1;
    end else begin
      exp_ready = 1'b1; exp_valid = 1'b0; chk_sum = 1'b0;
    end
  endtask

  task automatic feed(input int p, input bit last);
    bus.prod_valid_i = 1'b1;
    bus.prod_i       = PW'(p);
    cycle();
    bus.prod_valid_i = 1'b0;
    bus.prod_i       = PW'($urandom);
    m_step(p);
    exp_ovf = m_ovf;
    if (last) begin
      exp_ready = 1'b0; exp_valid = 1'b1; exp_sum = m_acc; chk_sum = 1'b1;
    end
  endtask

  // Whole run from pq: gaps up to max_gap, sum held hold_cyc cycles, optional
  // start/prod pokes during HOLD, optional literal pin on the held sum.
  task automatic run(input int max_gap, input int hold_cyc, input bit poke,
                     input bit use_lit, input int lit);
    int len;
    len = pq.size();
    begin_run(len);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, max_gap)) cycle();
      feed(pq[i], i == len - 1);
    end
    if (use_lit) chk("literal_sum", int'($signed(bus.sum_o)), lit);
    bus.start_i      = poke;
    bus.prod_valid_i = poke;
    bus.len_i        = CW'(3);
    repeat (hold_cyc) cycle();
    bus.start_i      = 1'b0;
    bus.prod_valid_i = 1'b0;
    bus.sum_ready_i  = 1'b1;
    cycle();
    bus.sum_ready_i  = 1'b0;
    idle_expect();
    chk_sum = 1'b0;
  endtask

  initial begin
    bus.start_i = 1'b0; bus.len_i = '0; bus.clr_i = 1'b0;
    bus.prod_i = '0; bus.prod_valid_i = 1'b0; bus.sum_ready_i = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    chk_sum = 1'b1; exp_sum = 0;
    chk_en = 1'b1;
    cycle();

    // Basic run, no gaps, immediate take
    pq.delete(); pq.push_back(5); pq.push_back(-7); pq.push_back(20);
    run(0, 0, 1'b0, 1'b1, 18);
    chk("ovf_after_18", int'(bus.ovf_o), 0);

    // Gapped run, long hold with ignored start/prod pokes
    pq.delete(); pq.push_back(33); pq.push_back(-90); pq.push_back(7); pq.push_back(-1);
    run(2, 5, 1'b1, 1'b1, -51);

    // Positive and negative overflow
    pq.delete(); repeat (5) pq.push_back(127);
`ifdef BOOTH_ACC_SATURATE_EN
    run(0, 1, 1'b0, 1'b1, 511);
`else
    run(0, 1, 1'b0, 1'b1, -389);
`endif
    chk("ovf_pos_sticky", int'(bus.ovf_o), 1);
    pq.delete(); repeat (5) pq.push_back(-128);
`ifdef BOOTH_ACC_SATURATE_EN
    run(1, 0, 1'b0, 1'b1, -512);
`else
    run(1, 0, 1'b0, 1'b1, 384);
`endif

    // clr_i in IDLE clears sticky ovf
    bus.clr_i = 1'b1; cycle(); bus.clr_i = 1'b0;
    exp_ovf = 1'b0; chk_sum = 1'b1; exp_sum = 0;
    cycle();

    // rst for two cycles while holding an overflowed sum
    begin_run(5);
    for (int i = 0; i < 5; i++) feed(127, i == 4);
    rst = 1'b1;
    cycle();
    idle_expect(); exp_ovf = 1'b0; chk_sum = 1'b1; exp_sum = 0;
    cycle();
    rst = 1'b0;
    pq.delete(); pq.push_back(-3); pq.push_back(9);
    run(0, 0, 1'b0, 1'b1, 6);

    // clr_i after two accepts drops the run
    begin_run(4);
    feed(100, 1'b0); feed(100, 1'b0);
    bus.clr_i = 1'b1; bus.prod_valid_i = 1'b1; bus.prod_i = PW'(50);
    cycle();
    bus.clr_i = 1'b0; bus.prod_valid_i = 1'b0;
    idle_expect(); exp_ovf = 1'b0; chk_sum = 1'b1; exp_sum = 0;
    cycle();
    pq.delete(); pq.push_back(-128);
    run(0, 0, 1'b0, 1'b1, -128);

    // clr_i in HOLD drops the unsent sum
    begin_run(2);
    feed(3, 1'b0); feed(4, 1'b1);
    bus.clr_i = 1'b1; cycle(); bus.clr_i = 1'b0;
    idle_expect(); exp_ovf = 1'b0; exp_sum = 0;
    cycle();

    // Zero-length run
    pq.delete();
    run(0, 2, 1'b0, 1'b1, 0);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      pq.delete();
      repeat ($urandom_range(0, 2**CW - 1)) pq.push_back($urandom_range(0, 255) - 128);
      run($urandom_range(0, 2), $urandom_range(0, 3), 1'(($urandom & 1)), 1'b0, 0);
      repeat ($urandom_range(0, 1)) cycle();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
